coord_shifter: RTL and testbench

//  Translates a signed point offset into absolute screen coordinates by adding
//  a per-object centre position (Xcenter, Ycenter). Sits in the rasteriser

---
 rtl/coord_shifter.sv | 111 +++++++++++
 tb/tb_coord_shifter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/coord_shifter.sv
// coord_shifter
//   Translates a signed point offset into an absolute, unsigned screen
//   coordinate by adding a per-object centre. Two-stage pipeline: one point per
//   clock, fixed 2-cycle latency. Axes that land off-screen are clamped to the
//   nearest edge, and the point is then reported as not valid.
//
// Ports
//   ACLK              clock, rising edge
//   ARESETN           asynchronous active-low reset, clears every pipeline flop
//   ENB               input qualifier; the point is accepted when 1 (no stall)
//   Xcoord, Ycoord    W-bit two's-complement offsets
//   Xcenter, Ycenter  W-bit unsigned centre position
//   Xout, Yout        W-bit unsigned translated (clamped) coordinates, registered
//   VALID             Xout/Yout hold an accepted, fully on-screen point
module coord_shifter #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         ENB,
  input  logic [W-1:0] Xcoord,
  input  logic [W-1:0] Ycoord,
  input  logic [W-1:0] Xcenter,
  input  logic [W-1:0] Ycenter,
  output logic [W-1:0] Xout,
  output logic [W-1:0] Yout,
  output logic         VALID
);

  // Two guard bits: the sum of a W-bit signed and a W-bit unsigned value
  // always fits in W+2 signed bits.
  function automatic logic signed [W+1:0] widen_add(
    input logic signed [W-1:0] coord,
    input logic        [W-1:0] center
  );
    widen_add = $signed({{2{coord[W-1]}}, coord}) + $signed({2'b00, center});
  endfunction

  // In range exactly when both guard bits are clear (0 .. 2^W-1).
  function automatic logic axis_in_range(input logic signed [W+1:0] sum);
    axis_in_range = (sum[W+1:W] == 2'b00);
  endfunction

  // Negative sums clamp to 0, sums above 2^W-1 clamp to all-ones.
  function automatic logic [W-1:0] sat_axis(input logic signed [W+1:0] sum);
    if (sum[W+1]) begin
      sat_axis = '0;
    end else if (sum[W]) begin
      sat_axis = '1;
    end else begin
      sat_axis = sum[W-1:0];
    end
  endfunction

  logic signed [W-1:0] x_coord_p1_q, x_coord_p1_d;
  logic signed [W-1:0] y_coord_p1_q, y_coord_p1_d;
  logic        [W-1:0] x_center_p1_q, x_center_p1_d;
  logic        [W-1:0] y_center_p1_q, y_center_p1_d;
  logic                vld_p1_q, vld_p1_d;

  logic signed [W+1:0] x_sum_p1, y_sum_p1;

  logic        [W-1:0] x_out_p2_q, x_out_p2_d;
  logic        [W-1:0] y_out_p2_q, y_out_p2_d;
  logic                vld_p2_q, vld_p2_d;

  // ---- stage 1: capture inputs unconditionally; ENB only tags validity ----
  always_comb begin
    x_coord_p1_d  = Xcoord;
    y_coord_p1_d  = Ycoord;
    x_center_p1_d = Xcenter;
    y_center_p1_d = Ycenter;
    vld_p1_d      = ENB;
  end

  // ---- stage 2: widen, add, range check and clamp per axis ----
  always_comb begin
    x_sum_p1   = widen_add(x_coord_p1_q, x_center_p1_q);
    y_sum_p1   = widen_add(y_coord_p1_q, y_center_p1_q);
    x_out_p2_d = sat_axis(x_sum_p1);
    y_out_p2_d = sat_axis(y_sum_p1);
    vld_p2_d   = vld_p1_q & axis_in_range(x_sum_p1) & axis_in_range(y_sum_p1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      x_coord_p1_q  <= '0;
      y_coord_p1_q  <= '0;
      x_center_p1_q <= '0;
      y_center_p1_q <= '0;
      vld_p1_q      <= 1'b0;
      x_out_p2_q    <= '0;
      y_out_p2_q    <= '0;
      vld_p2_q      <= 1'b0;
    end else begin
      x_coord_p1_q  <= x_coord_p1_d;
      y_coord_p1_q  <= y_coord_p1_d;
      x_center_p1_q <= x_center_p1_d;
      y_center_p1_q <= y_center_p1_d;
      vld_p1_q      <= vld_p1_d;
      x_out_p2_q    <= x_out_p2_d;
      y_out_p2_q    <= y_out_p2_d;
      vld_p2_q      <= vld_p2_d;
    end
  end

  assign Xout  = x_out_p2_q;
  assign Yout  = y_out_p2_q;
  assign VALID = vld_p2_q;

endmodule

// File: tb/tb_coord_shifter.sv
module tb_coord_shifter;

  localparam int W = 8;

  logic         ACLK;
  logic         ARESETN;
  logic         ENB;
  logic [W-1:0] Xcoord, Ycoord, Xcenter, Ycenter;
  logic [W-1:0] Xout, Yout;
  logic         VALID;

  int n_checks;
  int n_fail;

  coord_shifter #(.W(W)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .ENB     (ENB),
    .Xcoord  (Xcoord),
    .Ycoord  (Ycoord),
    .Xcenter (Xcenter),
    .Ycenter (Ycenter),
    .Xout    (Xout),
    .Yout    (Yout),
    .VALID   (VALID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] xc, input logic [7:0] xcen,
                       input logic [7:0] yc, input logic [7:0] ycen);
    ENB     = en;
    Xcoord  = xc;
    Xcenter = xcen;
    Ycoord  = yc;
    Ycenter = ycen;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                         input logic ev);
    chk({tag, ".x"}, {8'h00, Xout}, {8'h00, ex});
    chk({tag, ".y"}, {8'h00, Yout}, {8'h00, ey});
    chk({tag, ".v"}, {15'h0, VALID}, {15'h0, ev});
  endtask

  // Behavioural reference using plain integer arithmetic.
  function automatic logic [7:0] ref_axis(input logic [7:0] c, input logic [7:0] cen);
    int s;
    s = int'($signed(c)) + int'(cen);
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  function automatic logic ref_in(input logic [7:0] c, input logic [7:0] cen);
    int s;
    s = int'($signed(c)) + int'(cen);
    return (s >= 0) && (s <= 255);
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] corners [6];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Stream table: en, xc, xcen, yc, ycen -> X, Y (hand computed)
  logic [7:0] s_xc   [6] = '{8'h01, 8'h03, 8'hFF, 8'h05, 8'h20, 8'h7F};
  logic [7:0] s_xcen [6] = '{8'h10, 8'h30, 8'h50, 8'hF0, 8'h00, 8'h80};
  logic [7:0] s_yc   [6] = '{8'h02, 8'h04, 8'h10, 8'hFE, 8'h00, 8'h80};
  logic [7:0] s_ycen [6] = '{8'h20, 8'h40, 8'h60, 8'h03, 8'h99, 8'h80};
  logic       s_en   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] s_ex   [6] = '{8'h11, 8'h33, 8'h4F, 8'hF5, 8'h20, 8'hFF};
  logic [7:0] s_ey   [6] = '{8'h22, 8'h44, 8'h70, 8'h01, 8'h99, 8'h00};

  localparam int NRND = 400;
  logic [7:0] r_xc [NRND];
  logic [7:0] r_xcen [NRND];
  logic [7:0] r_yc [NRND];
  logic [7:0] r_ycen [NRND];
  logic       r_en [NRND];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ARESETN  = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    chk_out("reset", 8'h00, 8'h00, 1'b0);
    step();
    step();
    chk_out("reset_held", 8'h00, 8'h00, 1'b0);
    #3 ARESETN = 1'b1;

    // Constant point, ENB held high
    drive(1'b1, 8'h00, 8'h20, 8'h00, 8'h00);
    step();
    chk("t1_lat1.v", {15'h0, VALID}, 16'h0000);
    step();
    chk_out("t1", 8'h20, 8'h00, 1'b1);
    step();
    chk_out("t1_steady", 8'h20, 8'h00, 1'b1);

    // Async reset mid-stream
    #2 ARESETN = 1'b0;
    #1;
    chk_out("t2_async", 8'h00, 8'h00, 1'b0);
    #2 ARESETN = 1'b1;
    drive(1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
    step();
    chk("t2_after_rel.v", {15'h0, VALID}, 16'h0000);
    drive(1'b1, 8'h01, 8'h02, 8'h03, 8'h04);
    step();
    chk("t2_one_rise.v", {15'h0, VALID}, 16'h0000);
    step();
    chk_out("t2_two_rises", 8'h03, 8'h07, 1'b1);

    // Negative offset to zero, small positive
    drive(1'b1, 8'hF0, 8'h10, 8'h05, 8'h0A);
    step(); step();
    chk_out("t3", 8'h00, 8'h0F, 1'b1);

    // Overflow / underflow clamps
    drive(1'b1, 8'h7F, 8'h90, 8'h00, 8'h00);
    step(); step();
    chk_out("t4_hi", 8'hFF, 8'h00, 1'b0);
    drive(1'b1, 8'h80, 8'h10, 8'h00, 8'h00);
    step(); step();
    chk_out("t4_lo", 8'h00, 8'h00, 1'b0);

    // Boundaries
    drive(1'b1, 8'h80, 8'h80, 8'h7F, 8'h80);
    step(); step();
    chk_out("bnd_edges", 8'h00, 8'hFF, 1'b1);
    drive(1'b1, 8'h7F, 8'h81, 8'h00, 8'h00);
    step(); step();
    chk_out("bnd_256", 8'hFF, 8'h00, 1'b0);
    drive(1'b1, 8'h7F, 8'hFF, 8'h80, 8'h00);
    step(); step();
    chk_out("both_out", 8'hFF, 8'h00, 1'b0);
    drive(1'b1, 8'h10, 8'h10, 8'h80, 8'h7F);
    step(); step();
    chk_out("y_only_out", 8'h20, 8'h00, 1'b0);

    // Six-point stream with bubbles, one result per clock
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(s_en[i], s_xc[i], s_xcen[i], s_yc[i], s_ycen[i]);
      else       drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      if (i >= 1) chk_out($sformatf("t5[%0d]", i - 1), s_ex[i-1], s_ey[i-1], s_en[i-1]);
    end

    // Random points against the integer reference
    for (int i = 0; i < NRND; i++) begin
      r_xc[i]   = pick();
      r_xcen[i] = pick();
      r_yc[i]   = pick();
      r_ycen[i] = pick();
      r_en[i]   = ($urandom_range(0, 4) != 0);
    end
    for (int i = 0; i <= NRND; i++) begin
      if (i < NRND) drive(r_en[i], r_xc[i], r_xcen[i], r_yc[i], r_ycen[i]);
      else          drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      if (i >= 1) begin
        chk_out($sformatf("rnd[%0d]", i - 1),
                ref_axis(r_xc[i-1], r_xcen[i-1]),
                ref_axis(r_yc[i-1], r_ycen[i-1]),
                r_en[i-1] & ref_in(r_xc[i-1], r_xcen[i-1]) & ref_in(r_yc[i-1], r_ycen[i-1]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
